// File: rtl/uart_cmd_controller_pkg.sv
// rtl/uart_cmd_controller_pkg.sv - opcode constants and one-hot state encoding for the UART command sequencer
package uart_cmd_pkg;

    localparam logic [7:0] OP_BRIGHT = 8'h4C;
    localparam logic [7:0] OP_ROW    = 8'h52;
    localparam logic [7:0] OP_SWAP   = 8'h46;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0001,
        ST_GET_BRIGHT = 4'b0010,
        ST_GET_ROW    = 4'b0100,
        ST_GET_PIXELS = 4'b1000
    } state_t;

endpackage

// File: rtl/uart_cmd_controller_if.sv
// rtl/uart_cmd_controller_if.sv - receiver byte stream and frame-buffer/panel control bundle
interface uart_cmd_if #(
    parameter int ADDR_W = 13
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_busy;
    logic              rx_enable;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic [7:0]        brightness;
    logic              frame_select;
    logic              swap;
    logic              cmd_err;
    logic              busy;

    // master: the command controller; slave: receiver and panel side
    modport master (
        input  rx_data, rx_valid, rx_busy,
        output rx_enable, ram_we, ram_addr, ram_data, brightness,
               frame_select, swap, cmd_err, busy
    );

    modport slave (
        output rx_data, rx_valid, rx_busy,
        input  rx_enable, ram_we, ram_addr, ram_data, brightness,
               frame_select, swap, cmd_err, busy
    );
endinterface

// File: rtl/uart_cmd_controller_timer.sv
// rtl/uart_cmd_controller_timer.sv - inter-byte timeout counter with single-cycle expire pulse
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_W      = 13
) (
    input  logic i_clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);
    logic [TIMEOUT_W-1:0] cnt;

    // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES; a clear that cycle suppresses it
    assign expire = run && !clear && (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || clear || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_cmd_controller.sv
// rtl/uart_cmd_controller.sv - decodes receiver bytes into frame-buffer writes, brightness and frame swaps
module uart_cmd_controller
    import uart_cmd_pkg::*;
#(
    parameter int ROWS           = 32,
    parameter int ROW_BYTES      = 192,
    parameter int ADDR_W         = 13,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_W      = 13
) (
    input  logic       i_clk,
    input  logic       reset,
    uart_cmd_if.master bus
);
    localparam int COL_W = $clog2(ROW_BYTES);

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        bright_q, bright_d;
    logic              fsel_q, fsel_d;
    logic              swap_q, swap_d;
    logic              err_q, err_d;
    logic              rx_en_q;
    logic              expire;

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_timer (
        .i_clk (i_clk),
        .reset (reset),
        .run   (state_q != ST_IDLE),
        .clear (bus.rx_valid || bus.rx_busy),
        .expire(expire)
    );

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            bright_q <= 8'hFF;
            fsel_q   <= 1'b0;
            swap_q   <= 1'b0;
            err_q    <= 1'b0;
            rx_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            base_q   <= base_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            bright_q <= bright_d;
            fsel_q   <= fsel_d;
            swap_q   <= swap_d;
            err_q    <= err_d;
            rx_en_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        base_d   = base_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        bright_d = bright_q;
        fsel_d   = fsel_q;
        swap_d   = 1'b0;
        err_d    = 1'b0;
        if (expire) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (bus.rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == OP_BRIGHT) begin
                        state_d = ST_GET_BRIGHT;
                    end else if (bus.rx_data == OP_ROW) begin
                        state_d = ST_GET_ROW;
                    end else if (bus.rx_data == OP_SWAP) begin
                        fsel_d = !fsel_q;
                        swap_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_GET_BRIGHT: begin
                    bright_d = bus.rx_data;
                    state_d  = ST_IDLE;
                end
                ST_GET_ROW: begin
                    if (32'(bus.rx_data) < ROWS) begin
                        base_d  = ADDR_W'(bus.rx_data) * ADDR_W'(ROW_BYTES);
                        col_d   = '0;
                        state_d = ST_GET_PIXELS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_GET_PIXELS: begin
                    we_d   = 1'b1;
                    addr_d = base_q + ADDR_W'(col_q);
                    data_d = bus.rx_data;
                    col_d  = col_q + 1'b1;
                    if (col_q == COL_W'(ROW_BYTES - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.rx_enable    = rx_en_q;
    assign bus.ram_we       = we_q;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_data     = data_q;
    assign bus.brightness   = bright_q;
    assign bus.frame_select = fsel_q;
    assign bus.swap         = swap_q;
    assign bus.cmd_err      = err_q;
    assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_cmd_controller.sv
// tb/tb_uart_cmd_controller.sv - self-checking bench for uart_cmd_controller
module tb_uart_cmd_controller;
    localparam int ROWS      = 32;
    localparam int ROW_BYTES = 192;
    localparam int ADDR_W    = 13;
    localparam int TMO       = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_if #(.ADDR_W(ADDR_W)) bus ();

    uart_cmd_controller #(
        .ROWS(ROWS), .ROW_BYTES(ROW_BYTES), .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TMO), .TIMEOUT_W(13)
    ) dut (
        .i_clk(clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Protocol-level reference: what the panel should see after each byte
    int          m_mode;   // 0 idle, 1 awaiting brightness, 2 awaiting row, 3 receiving payload
    int          m_base, m_col;
    logic [7:0]  m_bright;
    logic        m_fsel;
    logic        e_we, e_swap, e_err;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]  e_data;

    typedef struct {
        logic [7:0] b;
        logic       we;
        logic       swap;
        logic       err;
        logic [7:0] bright;
        logic       fsel;
        logic       busy;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_base = 0; m_col = 0;
        m_bright = 8'hFF; m_fsel = 1'b0;
        e_we = 0; e_swap = 0; e_err = 0; e_addr = '0; e_data = '0;
    endtask

    task automatic model_idle();
        e_we = 0; e_swap = 0; e_err = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        model_idle();
        case (m_mode)
            0: begin
                if (b == 8'h4C) m_mode = 1;
                else if (b == 8'h52) m_mode = 2;
                else if (b == 8'h46) begin m_fsel = !m_fsel; e_swap = 1; end
                else e_err = 1;
            end
            1: begin m_bright = b; m_mode = 0; end
            2: begin
                if (int'(b) < ROWS) begin m_base = int'(b) * ROW_BYTES; m_col = 0; m_mode = 3; end
                else begin e_err = 1; m_mode = 0; end
            end
            default: begin
                e_we = 1; e_addr = ADDR_W'(m_base + m_col); e_data = b;
                m_col++;
                if (m_col == ROW_BYTES) m_mode = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ram_we"},   32'(bus.ram_we),       32'(e_we));
        chk({tag, ".ram_addr"}, 32'(bus.ram_addr),     32'(e_addr));
        chk({tag, ".ram_data"}, 32'(bus.ram_data),     32'(e_data));
        chk({tag, ".swap"},     32'(bus.swap),         32'(e_swap));
        chk({tag, ".cmd_err"},  32'(bus.cmd_err),      32'(e_err));
        chk({tag, ".bright"},   32'(bus.brightness),   32'(m_bright));
        chk({tag, ".fsel"},     32'(bus.frame_select), 32'(m_fsel));
        chk({tag, ".busy"},     32'(bus.busy),         32'(m_mode != 0));
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        model_byte(b);
        check_all(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_idle();
            check_all(tag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h4C, 0, 0, 0, 8'hFF, 0, 1};
        vecs[1] = '{8'h20, 0, 0, 0, 8'h20, 0, 0};
        vecs[2] = '{8'h46, 0, 1, 0, 8'h20, 1, 0};
        vecs[3] = '{8'h46, 0, 1, 0, 8'h20, 0, 0};
        vecs[4] = '{8'h52, 0, 0, 0, 8'h20, 0, 1};
        vecs[5] = '{8'h20, 0, 0, 1, 8'h20, 0, 0};
        vecs[6] = '{8'h7A, 0, 0, 1, 8'h20, 0, 0};
        vecs[7] = '{8'h4C, 0, 0, 0, 8'h20, 0, 1};
        vecs[8] = '{8'h00, 0, 0, 0, 8'h00, 0, 0};
        vecs[9] = '{8'h46, 0, 1, 0, 8'h00, 1, 0};

        bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_busy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.rx_enable", 32'(bus.rx_enable), 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rx_enable_after_reset", 32'(bus.rx_enable), 1);
        check_all("post_reset");

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].b, "table");
            chk($sformatf("vec%0d.we", i),     32'(bus.ram_we),       32'(vecs[i].we));
            chk($sformatf("vec%0d.swap", i),   32'(bus.swap),         32'(vecs[i].swap));
            chk($sformatf("vec%0d.err", i),    32'(bus.cmd_err),      32'(vecs[i].err));
            chk($sformatf("vec%0d.bright", i), 32'(bus.brightness),   32'(vecs[i].bright));
            chk($sformatf("vec%0d.fsel", i),   32'(bus.frame_select), 32'(vecs[i].fsel));
            chk($sformatf("vec%0d.busy", i),   32'(bus.busy),         32'(vecs[i].busy));
        end

        // Full row 3, back-to-back bytes: addresses 576..767
        send(8'h52, "row3.op");
        send(8'h03, "row3.idx");
        for (int i = 0; i < ROW_BYTES; i++) begin
            send(8'(i), "row3.px");
            chk("row3.addr_abs", 32'(bus.ram_addr), 32'(576 + i));
        end
        chk("row3.busy_after", 32'(bus.busy), 0);
        idle_cycles(2, "row3.after");

        // Busy freezes the timeout; silence afterwards expires it
        send(8'h52, "tmo.op");
        send(8'h01, "tmo.idx");
        for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), "tmo.px");
        @(negedge clk) bus.rx_busy = 1'b1;
        idle_cycles(TMO + 900, "tmo.frozen");
        @(negedge clk) bus.rx_busy = 1'b0;
        for (int i = 5; i < 10; i++) send(8'(8'hA0 + i), "tmo.px");
        idle_cycles(TMO - 1, "tmo.wait");
        @(posedge clk);
        #1;
        model_idle();
        e_err = 1;
        m_mode = 0;
        check_all("tmo.expire");
        idle_cycles(3, "tmo.after");
        send(8'h4C, "tmo.L");
        send(8'h10, "tmo.L_arg");
        chk("tmo.bright", 32'(bus.brightness), 32'h10);

        // Byte landing on the expiry cycle wins
        send(8'h52, "edge.op");
        send(8'h02, "edge.idx");
        send(8'h11, "edge.px0");
        idle_cycles(TMO - 1, "edge.wait");
        send(8'h22, "edge.px1");
        chk("edge.no_err", 32'(bus.cmd_err), 0);
        chk("edge.we", 32'(bus.ram_we), 1);
        for (int i = 2; i < ROW_BYTES; i++) send(8'($urandom), "edge.px");
        chk("edge.busy_after", 32'(bus.busy), 0);

        // Reset mid-row after 50 payload bytes
        send(8'h52, "rst.op");
        send(8'h05, "rst.idx");
        for (int i = 0; i < 50; i++) send(8'(i + 7), "rst.px");
        @(negedge clk);
        bus.rx_data = 8'h99;
        bus.rx_valid = 1'b1;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all("rst.async");
        chk("rst.rx_enable", 32'(bus.rx_enable), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("rst.held");
        end
        bus.rx_valid = 1'b0;
        @(negedge clk) reset = 1'b0;
        idle_cycles(2, "rst.release");
        chk("rst.rx_enable_back", 32'(bus.rx_enable), 1);

        // Randomized byte stream against the reference
        for (int n = 0; n < 1500; n++) begin
            int sel;
            logic [7:0] b;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    b = 8'h52;
                2:       b = 8'h4C;
                3:       b = 8'h46;
                4, 5:    b = 8'($urandom_range(0, 40));
                default: b = 8'($urandom);
            endcase
            send(b, "rand");
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), "rand.gap");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
